pwm_timer: RTL and testbench



---
 rtl/pwm_timer_pkg.sv | 14 +
 rtl/pwm_timer_if.sv | 24 ++
 rtl/pwm_timer_shadow_regs.sv | 53 +++++
 rtl/pwm_timer.sv | 114 +++++++++++
 tb/tb_pwm_timer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_timer_pkg.sv
// Shared constants and types for the PWM timebase (pwm_timer) and its register slice.
package pwm_pkg;

    localparam int unsigned PWM_WIDTH_DEFAULT = 16;

    localparam logic PWM_ADDR_PERIOD  = 1'b0;
    localparam logic PWM_ADDR_COMPARE = 1'b1;

    typedef enum logic {
        PWM_IDLE = 1'b0,
        PWM_RUN  = 1'b1
    } pwm_state_e;

endpackage

// File: rtl/pwm_timer_if.sv
// Register write port of pwm_timer: one write per cycle, no back-pressure.
interface pwm_timer_if
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH_DEFAULT
);

    logic             wr_en;
    logic             wr_addr;
    logic [WIDTH-1:0] wr_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input wr_en,
        input wr_addr,
        input wr_data
    );

endinterface

// File: rtl/pwm_timer_shadow_regs.sv
// Shadow/active PERIOD and COMPARE registers; active copies load on the counter's load strobe.
module pwm_shadow_regs
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             load,
    output logic [WIDTH-1:0] period_act,
    output logic [WIDTH-1:0] compare_act
);

    logic [WIDTH-1:0] period_sh_q,  period_sh_d;
    logic [WIDTH-1:0] compare_sh_q, compare_sh_d;
    logic [WIDTH-1:0] period_act_q, period_act_d;
    logic [WIDTH-1:0] compare_act_q, compare_act_d;

    always_comb begin
        period_sh_d   = period_sh_q;
        compare_sh_d  = compare_sh_q;
        period_act_d  = period_act_q;
        compare_act_d = compare_act_q;
        if (wr_en && (wr_addr == PWM_ADDR_PERIOD))  period_sh_d  = wr_data;
        if (wr_en && (wr_addr == PWM_ADDR_COMPARE)) compare_sh_d = wr_data;
        // Load from the post-write shadow so a write in the load cycle lands in active too.
        if (load) begin
            period_act_d  = period_sh_d;
            compare_act_d = compare_sh_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_sh_q   <= '0;
            compare_sh_q  <= '0;
            period_act_q  <= '0;
            compare_act_q <= '0;
        end else begin
            period_sh_q   <= period_sh_d;
            compare_sh_q  <= compare_sh_d;
            period_act_q  <= period_act_d;
            compare_act_q <= compare_act_d;
        end
    end

    assign period_act  = period_act_q;
    assign compare_act = compare_act_q;

endmodule

// File: rtl/pwm_timer.sv
// PWM timebase issuing registered set/reset pulses for an SR-latch output stage.
// Optional sticky period-end flag `irq` when PWM_TIMER_IRQ_EN is defined.
module pwm_timer
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    pwm_timer_if.slave       bus,
    output logic             s_pulse,
    output logic             r_pulse,
    output logic [WIDTH-1:0] count
`ifdef PWM_TIMER_IRQ_EN
    ,
    output logic             irq
`endif
);

    pwm_state_e       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             load;
    logic [WIDTH-1:0] period_act;
    logic [WIDTH-1:0] compare_act;

    pwm_shadow_regs #(
        .WIDTH (WIDTH)
    ) u_regs (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (bus.wr_en),
        .wr_addr     (bus.wr_addr),
        .wr_data     (bus.wr_data),
        .load        (load),
        .period_act  (period_act),
        .compare_act (compare_act)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        s_d     = 1'b0;
        r_d     = 1'b0;
        load    = 1'b0;
        case (state_q)
            PWM_IDLE: begin
                if (en) begin
                    state_d = PWM_RUN;
                    count_d = '0;
                    load    = 1'b1;
                end
            end
            PWM_RUN: begin
                if (!en) begin
                    // Leaving RUN forces the latch low with a final reset pulse.
                    state_d = PWM_IDLE;
                    count_d = '0;
                    r_d     = 1'b1;
                end else begin
                    s_d = (count_q == '0) && (compare_act != '0);
                    r_d = (count_q == compare_act);
                    if (count_q == period_act) begin
                        count_d = '0;
                        load    = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PWM_IDLE;
            count_q <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            s_q     <= s_d;
            r_q     <= r_d;
        end
    end

    assign s_pulse = s_q;
    assign r_pulse = r_q;
    assign count   = count_q;

`ifdef PWM_TIMER_IRQ_EN
    logic irq_q, irq_d;
    logic wrap;

    assign wrap = (state_q == PWM_RUN) && en && (count_q == period_act);

    always_comb begin
        irq_d = irq_q;
        if (bus.wr_en && (bus.wr_addr == PWM_ADDR_COMPARE)) irq_d = 1'b0;
        if (wrap) irq_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) irq_q <= 1'b0;
        else      irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_pwm_timer.sv
// Directed self-checking bench for pwm_timer; irq checks compile in with PWM_TIMER_IRQ_EN.
module tb_pwm_timer;
    import pwm_pkg::*;

    logic        clk;
    logic        rst;
    logic        en;
    logic        s_pulse;
    logic        r_pulse;
    logic [15:0] count;
`ifdef PWM_TIMER_IRQ_EN
    logic        irq;
`endif

    int errors = 0;
    int checks = 0;

    pwm_timer_if #(.WIDTH(16)) bus ();

    pwm_timer #(
        .WIDTH (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .bus     (bus),
        .s_pulse (s_pulse),
        .r_pulse (r_pulse),
        .count   (count)
`ifdef PWM_TIMER_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic a, input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic stop_run();
        en = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({s_pulse, r_pulse, count} !== 18'd0) begin
                errors++;
                $display("FAIL reset_hold i=%0d got s=%b r=%b count=%0d exp all 0", i, s_pulse, r_pulse, count);
            end
        end
        en  = 1'b0;
        rst = 1'b1;
        step();
        checks++;
        if ({s_pulse, r_pulse, count} !== 18'd0) begin
            errors++;
            $display("FAIL reset_release got s=%b r=%b count=%0d exp all 0", s_pulse, r_pulse, count);
        end
    endtask

    // Run for n cycles after en rises, checking pulses against the period-10 pattern.
    task automatic run_check(input string name, input int n, input int s_at, input int r_at);
        logic es, er;
        en = 1'b1;
        step();
        for (int k = 0; k < n; k++) begin
            es = (s_at >= 0) && (k >= 1) && (((k - 1) % 10) == s_at);
            er = (r_at >= 0) && (k >= 1) && (((k - 1) % 10) == r_at);
            checks++;
            if ({s_pulse, r_pulse} !== {es, er} || count !== 16'(k % 10)) begin
                errors++;
                $display("FAIL %s k=%0d got s=%b r=%b count=%0d exp s=%b r=%b count=%0d",
                         name, k, s_pulse, r_pulse, count, es, er, k % 10);
            end
            step();
        end
    endtask

    task automatic test_basic();
        wr(PWM_ADDR_PERIOD, 16'd9);
        wr(PWM_ADDR_COMPARE, 16'd3);
        run_check("basic", 25, 0, 3);
        stop_run();
    endtask

    task automatic test_duty_limits();
        wr(PWM_ADDR_COMPARE, 16'd0);
        run_check("duty0", 21, -1, 0);
        stop_run();
        wr(PWM_ADDR_COMPARE, 16'd12);
        run_check("duty100", 21, 0, -1);
        stop_run();
    endtask

    task automatic test_shadow();
        logic es, er;
        wr(PWM_ADDR_COMPARE, 16'd3);
        en = 1'b1;
        step();
        for (int k = 0; k <= 30; k++) begin
            es = (k == 1) || (k == 11) || (k == 21);
            er = (k == 4) || (k == 18) || (k == 23);
            checks++;
            if ({s_pulse, r_pulse} !== {es, er} || count !== 16'(k % 10)) begin
                errors++;
                $display("FAIL shadow k=%0d got s=%b r=%b count=%0d exp s=%b r=%b count=%0d",
                         k, s_pulse, r_pulse, count, es, er, k % 10);
            end
            if (k == 4 || k == 19) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = PWM_ADDR_COMPARE;
                bus.wr_data = (k == 4) ? 16'd7 : 16'd2;
            end
            step();
            bus.wr_en = 1'b0;
        end
        stop_run();
    endtask

    task automatic test_en_toggle();
        logic [8:0] exp_s = 9'b010000010;
        logic [8:0] exp_r = 9'b000001000;
        int exp_c[9] = '{0, 1, 2, 0, 0, 0, 0, 1, 2};
        wr(PWM_ADDR_COMPARE, 16'd5);
        en = 1'b1;
        step();
        for (int k = 0; k < 9; k++) begin
            checks++;
            if ({s_pulse, r_pulse} !== {exp_s[k], exp_r[k]} || count !== 16'(exp_c[k])) begin
                errors++;
                $display("FAIL en_toggle k=%0d got s=%b r=%b count=%0d exp s=%b r=%b count=%0d",
                         k, s_pulse, r_pulse, count, exp_s[k], exp_r[k], exp_c[k]);
            end
            if (k == 2) en = 1'b0;
            if (k == 5) en = 1'b1;
            step();
        end
        stop_run();
    endtask

    task automatic test_period_zero();
        logic es, er;
        wr(PWM_ADDR_PERIOD, 16'd0);
        wr(PWM_ADDR_COMPARE, 16'd1);
        en = 1'b1;
        step();
        for (int k = 0; k <= 9; k++) begin
            es = (k >= 1) && (k <= 6);
            er = (k >= 7);
            checks++;
            if ({s_pulse, r_pulse} !== {es, er} || count !== 16'd0) begin
                errors++;
                $display("FAIL period0 k=%0d got s=%b r=%b count=%0d exp s=%b r=%b count=0",
                         k, s_pulse, r_pulse, count, es, er);
            end
            if (k == 5) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = PWM_ADDR_COMPARE;
                bus.wr_data = 16'd0;
            end
            step();
            bus.wr_en = 1'b0;
        end
        stop_run();
    endtask

    task automatic test_reset_mid();
        wr(PWM_ADDR_PERIOD, 16'd9);
        wr(PWM_ADDR_COMPARE, 16'd3);
        en = 1'b1;
        step();
        step();
        checks++;
        if (s_pulse !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre got s=%b exp s=1", s_pulse);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({s_pulse, r_pulse, count} !== 18'd0) begin
            errors++;
            $display("FAIL reset_mid_async got s=%b r=%b count=%0d exp all 0", s_pulse, r_pulse, count);
        end
        step();
        step();
        checks++;
        if ({s_pulse, r_pulse, count} !== 18'd0) begin
            errors++;
            $display("FAIL reset_mid_hold got s=%b r=%b count=%0d exp all 0", s_pulse, r_pulse, count);
        end
        en  = 1'b0;
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({s_pulse, r_pulse, count} !== 18'd0) begin
            errors++;
            $display("FAIL reset_mid_after got s=%b r=%b count=%0d exp all 0", s_pulse, r_pulse, count);
        end
        // Active registers were cleared, so COMPARE=0 gives a reset pulse and no set pulse.
        en = 1'b1;
        step();
        step();
        checks++;
        if ({s_pulse, r_pulse} !== 2'b01) begin
            errors++;
            $display("FAIL reset_mid_regs got s=%b r=%b exp s=0 r=1", s_pulse, r_pulse);
        end
        stop_run();
    endtask

`ifdef PWM_TIMER_IRQ_EN
    task automatic test_irq();
        logic [10:0] exp_irq = 11'b10001100000;
        wr(PWM_ADDR_PERIOD, 16'd4);
        wr(PWM_ADDR_COMPARE, 16'd2);
        en = 1'b1;
        step();
        for (int k = 0; k <= 10; k++) begin
            checks++;
            if (irq !== exp_irq[k] || count !== 16'(k % 5)) begin
                errors++;
                $display("FAIL irq k=%0d got irq=%b count=%0d exp irq=%b count=%0d",
                         k, irq, count, exp_irq[k], k % 5);
            end
            if (k == 6 || k == 9) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = PWM_ADDR_COMPARE;
                bus.wr_data = 16'd2;
            end
            step();
            bus.wr_en = 1'b0;
        end
        stop_run();
    endtask
`endif

    initial begin
        rst         = 1'b0;
        en          = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 1'b0;
        bus.wr_data = '0;
        test_reset();
        test_basic();
        test_duty_limits();
        test_shadow();
        test_en_toggle();
        test_period_zero();
        test_reset_mid();
`ifdef PWM_TIMER_IRQ_EN
        test_irq();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
